// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Grant states, master indices, access-type width and the beat-counter width helper.
package dmem_arbiter_pkg;

    // Grant ownership: nobody, core (M0) or loader/DMA (M1).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Master indices, also used as the value of the "last owner" flag.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Width of store/load type fields (RV32I funct3).
    localparam int TYPE_W = 3;

    // Counter width for 0..max_burst-1; at least one bit, even for max_burst == 1.
    function automatic int beat_cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin chooser.
// On a tie the master that did not own the memory most recently wins;
// with a single requester that requester is chosen.
module rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       sel_o,
    output logic       any_o
);

    // Tie goes to the opposite of the last owner, otherwise to the lone requester.
    always_comb begin
        sel_o = M0;
        any_o = |req_i;
        if (req_i == 2'b11) begin
            sel_o = ~last_i;
        end else if (req_i[1]) begin
            sel_o = M1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single data_mem port.
// M0 is the RV32I core, M1 the external loader/DMA. Grant is a Moore function of
// the state register; the owner keeps the port for at most MAX_BURST consecutive
// beats while the other master is waiting. Read data comes back registered, one
// cycle after the read beat, on the owning master's rdata/rvalid.
//
// Handshake: mX_req is held until the beat is accepted. A beat is accepted at the
// rising edge that ends a cycle in which mX_gnt=1 and mX_req=1; mX_stall is simply
// mX_req & ~mX_gnt. A read beat returns data with mX_rvalid=1 for exactly one cycle
// in the following cycle; write beats return nothing.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    localparam int CNT_W    = beat_cnt_w(MAX_BURST)
) (
    input  logic              clk,
    input  logic              reset,

    // Master 0: core
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [TYPE_W-1:0] m0_store_t,
    input  logic [TYPE_W-1:0] m0_load_t,
    output logic              m0_gnt,
    output logic              m0_stall,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    // Master 1: loader / DMA
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [TYPE_W-1:0] m1_store_t,
    input  logic [TYPE_W-1:0] m1_load_t,
    output logic              m1_gnt,
    output logic              m1_stall,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    // data_mem port
    output logic [ADDR_W-1:0] dAddr,
    output logic [DATA_W-1:0] dWdata,
    output logic              d_wr_en,
    output logic [TYPE_W-1:0] store_type,
    output logic [TYPE_W-1:0] load_type,
    input  logic [DATA_W-1:0] dRdata,

    // Observability
    output arb_state_t        dbg_state_o,
    output logic [CNT_W-1:0]  dbg_beat_cnt_o
);

    // Beat count at which a contested owner must hand over.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              pick_sel;
    logic              pick_any;
    logic              beat0, beat1;
    logic              rd_beat0, rd_beat1;

    // Round-robin choice used when leaving IDLE.
    rr_pick2 u_pick (
        .req_i  ({m1_req, m0_req}),
        .last_i (last_q),
        .sel_o  (pick_sel),
        .any_o  (pick_any)
    );

    assign m0_gnt   = (state_q == OWN0);
    assign m1_gnt   = (state_q == OWN1);
    assign m0_stall = m0_req & ~m0_gnt;
    assign m1_stall = m1_req & ~m1_gnt;

    assign beat0    = m0_gnt & m0_req;
    assign beat1    = m1_gnt & m1_req;
    assign rd_beat0 = beat0 & ~m0_we;
    assign rd_beat1 = beat1 & ~m1_we;

    // Next grant state, last-owner flag and burst beat counter.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = (pick_sel == M1) ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_d = m1_req ? OWN1 : IDLE;
                end else if (m1_req && (cnt_q == CNT_MAX)) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_d = m0_req ? OWN0 : IDLE;
                end else if (m0_req && (cnt_q == CNT_MAX)) begin
                    state_d = OWN0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new owner starts a fresh burst; the same owner counts its beats,
        // saturating so an uncontested owner can keep the port indefinitely.
        if ((state_d != state_q) && (state_d != IDLE)) begin
            cnt_d  = '0;
            last_d = (state_d == OWN1) ? M1 : M0;
        end else if ((beat0 || beat1) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Grant FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= M1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Route the owner's request fields to data_mem; nothing is driven in IDLE.
    always_comb begin
        dAddr      = '0;
        dWdata     = '0;
        d_wr_en    = 1'b0;
        store_type = '0;
        load_type  = '0;
        unique case (state_q)
            OWN0: begin
                dAddr      = m0_addr;
                dWdata     = m0_wdata;
                d_wr_en    = m0_req & m0_we;
                store_type = m0_store_t;
                load_type  = m0_load_t;
            end
            OWN1: begin
                dAddr      = m1_addr;
                dWdata     = m1_wdata;
                d_wr_en    = m1_req & m1_we;
                store_type = m1_store_t;
                load_type  = m1_load_t;
            end
            default: begin
                dAddr      = '0;
                dWdata     = '0;
                d_wr_en    = 1'b0;
                store_type = '0;
                load_type  = '0;
            end
        endcase
    end

    // Capture read data for the master whose read beat completes; rdata holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= rd_beat0;
            rvalid1_q <= rd_beat1;
            if (rd_beat0) begin
                rdata0_q <= dRdata;
            end
            if (rd_beat1) begin
                rdata1_q <= dRdata;
            end
        end
    end

    assign m0_rvalid      = rvalid0_q;
    assign m0_rdata       = rdata0_q;
    assign m1_rvalid      = rvalid1_q;
    assign m1_rdata       = rdata1_q;
    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = cnt_q;

endmodule
